ps2_key_controller: RTL and testbench
=====================================

PS2_KEY_CONTROLLER -- requirements
Module: ps2_key_controller

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- FIFO_DEPTH, 4, key-event FIFO entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 50000, Clk cycles without a KB_Clk falling edge before a partial frame is abandoned.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- Clk  in  1  system clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- KB_Clk  in  1  raw PS/2 clock, asynchronous to Clk.
- KB_Data  in  1  raw PS/2 data, asynchronous to Clk.
- Rd_En  in  1  pop head event.
- Key_Valid  out  1  FIFO non-empty.
- Key_Code  out  8  head event scan code.
- Key_Release  out  1  head event was preceded by F0.
- Key_Extended  out  1  head event was preceded by E0.
- Overflow  out  1  sticky; an event was dropped.
- Frame_Err  out  1  one-cycle pulse on a bad or abandoned frame.

Function
REQ-003 KB_Clk and KB_Data SHALL each pass through a 2-flop synchronizer; a falling edge is synced KB_Clk 1 in the previous cycle and 0 in the current cycle.
REQ-004 Frame FSM states SHALL be IDLE, DATA, PARITY, STOP; transitions occur only on a detected falling edge, except for the timeout.
- IDLE: synced data 0 -> DATA, bit count 0; synced data 1 -> stay in IDLE, no error.
- DATA: shift the data bit in LSB first; after the 8th bit -> PARITY.
- PARITY: capture the bit -> STOP.
- STOP: data 1 with good parity -> byte_done pulse for one cycle; otherwise Frame_Err pulse and the byte is discarded; -> IDLE either way.
REQ-005 Outside IDLE, a watchdog SHALL count Clk cycles and clear on each falling edge; on reaching TIMEOUT_CYCLES the FSM returns to IDLE and Frame_Err pulses for one cycle.
REQ-006 Decoder on byte_done:
- 8'hE0 sets the ext flag.
- 8'hF0 sets the rel flag.
- Any other byte pushes the event {ext, rel, code} and clears both flags.
- Prefix bytes are never pushed.
REQ-007 Flags SHALL persist across frames; a Frame_Err SHALL clear both flags.
REQ-008 The FIFO SHALL be show-ahead: Key_Code, Key_Release and Key_Extended reflect the head entry whenever Key_Valid is 1. Outputs are don't-care when Key_Valid is 0.
REQ-009 A push at cycle N into an empty FIFO SHALL raise Key_Valid at cycle N+1.
REQ-010 Rd_En while Key_Valid is 0 SHALL be ignored.
REQ-011 A push while the FIFO is full, without a simultaneous pop, SHALL drop the new event and set Overflow, which holds until Reset.
REQ-012 A push and pop in the same cycle SHALL both take effect, including when full (no overflow) and when holding one entry (count unchanged).
REQ-013 Pointers SHALL be log2(FIFO_DEPTH) bits wide and wrap naturally; the count SHALL be one bit wider than the pointers.

Reset
REQ-014 Reset SHALL set:
- FSM to IDLE; bit count, watchdog, ext and rel flags to 0;
- FIFO empty, Key_Valid 0, Overflow 0, Frame_Err 0;
- synchronizer flops to 1 (bus idle).
REQ-015 Reset asserted mid-frame SHALL abandon the frame without a Frame_Err pulse; the next start bit after release is decoded normally.

Configuration
REQ-016 With PS2_PARITY_CHECK_EN defined, a parity bit that does not give odd parity over the 8 data bits plus parity SHALL cause Frame_Err and discard the byte. Undefined: the parity bit is sampled and ignored, and only the stop bit is checked.

Structure
REQ-017 Package ps2_pkg SHALL hold:
- the FSM state enum;
- the constants PS2_EXT = 8'hE0 and PS2_REL = 8'hF0;
- the 10-bit key event struct {ext, rel, code[7:0]}.
REQ-018 The FIFO SHALL be the sub-module ps2_key_fifo; the synchronizer, FSM and decoder stay in ps2_key_controller.

Verification
REQ-019 Bench scenarios, each stimulus -> required response:
- Frame 8'h1C with good parity -> one event {0,0,1C}; Key_Valid 1 cycle after byte_done; Rd_En empties the FIFO.
- Frames E0, F0, 75 -> a single event {1,1,75}; prefixes not queued.
- Five codes 01..05, no reads, FIFO_DEPTH=4 -> codes 01..04 read in order, Overflow=1; push plus pop on a full FIFO -> no overflow.
- Parity bit flipped on 8'h1C -> with PS2_PARITY_CHECK_EN: Frame_Err pulse, no event; without it: event 1C.
- KB_Clk stalled after 4 data bits for TIMEOUT_CYCLES -> Frame_Err pulse, FSM IDLE; the next full frame decodes correctly.
- Reset asserted mid-frame with 2 events queued -> Key_Valid 0, Overflow 0, no Frame_Err; the next frame decodes.

Source files
------------

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared types and constants for the PS/2 keyboard controller:
//   - ps2_state_e : frame receiver FSM states
//   - PS2_EXT     : extended-key prefix byte (E0)
//   - PS2_REL     : key-release prefix byte (F0)
//   - key_event_t : queued key event {ext, rel, code[7:0]}
//   - odd_parity_ok : parity helper for data byte plus parity bit
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_REL = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } key_event_t;

    // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// ---------------------------------------------------------------------------
// ps2_key_fifo
// Show-ahead FIFO of decoded key events. The head entry is presented on
// head_o whenever valid_o is high. Pops on an empty FIFO are ignored; a push
// into a full FIFO without a simultaneous pop is dropped and sets a sticky
// overflow flag. Push and pop in the same cycle both take effect.
// Ports:
//   clk_i       system clock
//   reset_i     synchronous active-high reset
//   push_i      write push_data_i
//   push_data_i event to enqueue
//   pop_i       remove head entry
//   valid_o     FIFO non-empty
//   head_o      head entry
//   overflow_o  sticky: an event was dropped
// ---------------------------------------------------------------------------
module ps2_key_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       push_i,
    input  key_event_t push_data_i,
    input  logic       pop_i,
    output logic       valid_o,
    output key_event_t head_o,
    output logic       overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    key_event_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          valid_q, valid_d;
    logic          overflow_q, overflow_d;
    logic          empty_s, full_s, pop_ok_s, push_ok_s, drop_s;

    // Pointer, count and flag next-state logic.
    always_comb begin
        empty_s   = (count_q == (AW+1)'(0));
        full_s    = (count_q == FULL_CNT);
        pop_ok_s  = pop_i && !empty_s;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok_s = push_i && (!full_s || pop_ok_s);
        drop_s    = push_i && full_s && !pop_ok_s;

        wr_ptr_d  = push_ok_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d  = pop_ok_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        valid_d    = (count_d != (AW+1)'(0));
        overflow_d = overflow_q | drop_s;
    end

    // FIFO state registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    // Event storage.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign valid_o    = valid_q;
    assign head_o     = mem_q[rd_ptr_q];
    assign overflow_o = overflow_q;

endmodule

// File: rtl/ps2_key_controller.sv
// ---------------------------------------------------------------------------
// ps2_key_controller
// Receives PS/2 keyboard frames (start, 8 data LSB first, parity, stop),
// folds E0/F0 prefix bytes into flags and queues {ext, rel, code} events in
// a show-ahead FIFO.
// Optional feature macro: PS2_PARITY_CHECK_EN -- when defined, frames with
// bad odd parity are rejected; when undefined only the stop bit is checked.
// Ports:
//   Clk          system clock (only clock)
//   Reset        synchronous active-high reset
//   KB_Clk       raw PS/2 clock (asynchronous)
//   KB_Data      raw PS/2 data (asynchronous)
//   Rd_En        pop head event
//   Key_Valid    FIFO non-empty
//   Key_Code     head event scan code
//   Key_Release  head event was preceded by F0
//   Key_Extended head event was preceded by E0
//   Overflow     sticky: an event was dropped
//   Frame_Err    one-cycle pulse on a bad or abandoned frame
// ---------------------------------------------------------------------------
module ps2_key_controller
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       KB_Clk,
    input  logic       KB_Data,
    input  logic       Rd_En,
    output logic       Key_Valid,
    output logic [7:0] Key_Code,
    output logic       Key_Release,
    output logic       Key_Extended,
    output logic       Overflow,
    output logic       Frame_Err
);

    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    // Synchronizer and edge detect.
    logic kb_clk_meta_q, kb_clk_sync_q, kb_clk_prev_q;
    logic kb_data_meta_q, kb_data_sync_q;
    logic kb_fall_s;

    // Frame receiver.
    ps2_state_e     state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           parity_q, parity_d;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic [7:0]     byte_q, byte_d;
    logic           byte_done_q, byte_done_d;
    logic           frame_err_q, frame_err_d;
    logic           timeout_s;
    logic           parity_calc_s, parity_good_s;

    // Decoder.
    logic       ext_q, ext_d;
    logic       rel_q, rel_d;
    logic       push_s;
    key_event_t push_ev_s;
    key_event_t head_s;

    // Two-flop synchronizers; held at 1 in reset to match an idle bus.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            kb_clk_meta_q  <= 1'b1;
            kb_clk_sync_q  <= 1'b1;
            kb_clk_prev_q  <= 1'b1;
            kb_data_meta_q <= 1'b1;
            kb_data_sync_q <= 1'b1;
        end else begin
            kb_clk_meta_q  <= KB_Clk;
            kb_clk_sync_q  <= kb_clk_meta_q;
            kb_clk_prev_q  <= kb_clk_sync_q;
            kb_data_meta_q <= KB_Data;
            kb_data_sync_q <= kb_data_meta_q;
        end
    end

    assign kb_fall_s     = kb_clk_prev_q && !kb_clk_sync_q;
    assign parity_calc_s = odd_parity_ok(shift_q, parity_q);

`ifdef PS2_PARITY_CHECK_EN
    assign parity_good_s = parity_calc_s;
`else
    // Parity bit is still sampled, but never rejects a frame.
    assign parity_good_s = parity_calc_s | 1'b1;
`endif

    // Frame FSM next-state, watchdog and result pulses.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        byte_d      = byte_q;
        byte_done_d = 1'b0;
        frame_err_d = 1'b0;

        if (state_q == ST_IDLE) begin
            wdog_d = '0;
        end else if (kb_fall_s) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + WDW'(1);
        end

        // The count reaches TIMEOUT_CYCLES on this cycle unless an edge clears it.
        timeout_s = (state_q != ST_IDLE) && !kb_fall_s &&
                    (wdog_q == WDW'(TIMEOUT_CYCLES - 1));

        if (timeout_s) begin
            state_d     = ST_IDLE;
            wdog_d      = '0;
            frame_err_d = 1'b1;
        end else if (kb_fall_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (!kb_data_sync_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_d   = {kb_data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    parity_d = kb_data_sync_q;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    if (kb_data_sync_q && parity_good_s) begin
                        byte_d      = shift_q;
                        byte_done_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Frame FSM registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            parity_q    <= 1'b0;
            wdog_q      <= '0;
            byte_q      <= 8'd0;
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            wdog_q      <= wdog_d;
            byte_q      <= byte_d;
            byte_done_q <= byte_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Prefix decoder: E0/F0 only set flags; any other byte becomes an event.
    always_comb begin
        ext_d     = ext_q;
        rel_d     = rel_q;
        push_s    = 1'b0;
        push_ev_s = '{ext: ext_q, rel: rel_q, code: byte_q};

        if (frame_err_q) begin
            ext_d = 1'b0;
            rel_d = 1'b0;
        end else if (byte_done_q) begin
            if (byte_q == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (byte_q == PS2_REL) begin
                rel_d = 1'b1;
            end else begin
                push_s = 1'b1;
                ext_d  = 1'b0;
                rel_d  = 1'b0;
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // Prefix flag registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ext_q <= 1'b0;
            rel_q <= 1'b0;
        end else begin
            ext_q <= ext_d;
            rel_q <= rel_d;
        end
    end

    ps2_key_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (Clk),
        .reset_i    (Reset),
        .push_i     (push_s),
        .push_data_i(push_ev_s),
        .pop_i      (Rd_En),
        .valid_o    (Key_Valid),
        .head_o     (head_s),
        .overflow_o (Overflow)
    );

    assign Key_Code     = head_s.code;
    assign Key_Release  = head_s.rel;
    assign Key_Extended = head_s.ext;
    assign Frame_Err    = frame_err_q;

endmodule

// File: tb/tb_ps2_key_controller.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_controller
// Directed bench: PS/2 frames are bit-banged onto KB_Clk/KB_Data, expected
// key events are queued when a frame is sent and compared against the FIFO
// head when read back.
// ---------------------------------------------------------------------------
module tb_ps2_key_controller;
    import ps2_pkg::*;

    localparam int DEPTH = 4;
    localparam int TO    = 200;
    localparam int HALF  = 8;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       KB_Clk;
    logic       KB_Data;
    logic       Rd_En;
    logic       Key_Valid;
    logic [7:0] Key_Code;
    logic       Key_Release;
    logic       Key_Extended;
    logic       Overflow;
    logic       Frame_Err;

    int tests  = 0;
    int fails  = 0;
    int fe_cnt = 0;
    key_event_t sb_q[$];

    ps2_key_controller #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .KB_Clk      (KB_Clk),
        .KB_Data     (KB_Data),
        .Rd_En       (Rd_En),
        .Key_Valid   (Key_Valid),
        .Key_Code    (Key_Code),
        .Key_Release (Key_Release),
        .Key_Extended(Key_Extended),
        .Overflow    (Overflow),
        .Frame_Err   (Frame_Err)
    );

    always #5 Clk = ~Clk;

    // Count Frame_Err pulses.
    always @(negedge Clk) begin
        if (Frame_Err === 1'b1) fe_cnt++;
    end

    // Hard stop in case something hangs.
    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge Clk);
        KB_Data = b;
        repeat (HALF) @(negedge Clk);
        KB_Clk = 1'b0;
        repeat (HALF) @(negedge Clk);
        KB_Clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i]);
        send_bit((~^code) ^ flip);
        send_bit(1'b1);
        repeat (HALF) @(negedge Clk);
    endtask

    task automatic expect_event(input logic ext, input logic rel, input logic [7:0] code);
        key_event_t ev;
        ev.ext  = ext;
        ev.rel  = rel;
        ev.code = code;
        sb_q.push_back(ev);
    endtask

    task automatic read_event(input string tag);
        key_event_t exp;
        int n = 0;
        while (Key_Valid !== 1'b1 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        check({tag, "_valid"}, {31'd0, Key_Valid}, 32'd1);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 10'h3FF;
        check({tag, "_event"}, {22'd0, Key_Extended, Key_Release, Key_Code}, {22'd0, exp});
        Rd_En = 1'b1;
        @(negedge Clk);
        Rd_En = 1'b0;
    endtask

    task automatic wait_byte_done(output int n);
        n = 0;
        while (dut.byte_done_q !== 1'b1 && n < 400) begin
            @(negedge Clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int fe_before;
        Reset   = 1'b1;
        KB_Clk  = 1'b1;
        KB_Data = 1'b1;
        Rd_En   = 1'b0;
        repeat (5) @(negedge Clk);
        check("rst_valid",    {31'd0, Key_Valid}, 32'd0);
        check("rst_overflow", {31'd0, Overflow},  32'd0);
        check("rst_frame_err",{31'd0, Frame_Err}, 32'd0);
        check("rst_state",    {30'd0, dut.state_q}, {30'd0, ST_IDLE});
        Reset = 1'b0;
        repeat (5) @(negedge Clk);

        // Rd_En on an empty FIFO is ignored.
        Rd_En = 1'b1;
        repeat (2) @(negedge Clk);
        Rd_En = 1'b0;
        @(negedge Clk);
        check("empty_pop_valid", {31'd0, Key_Valid}, 32'd0);

        // Single frame 1C, Key_Valid one cycle after byte_done.
        fork
            send_frame(8'h1C, 1'b0);
            begin
                wait_byte_done(n);
                check("bd_seen", {31'd0, dut.byte_done_q}, 32'd1);
                check("valid_at_bd", {31'd0, Key_Valid}, 32'd0);
                @(negedge Clk);
                check("valid_bd_plus1", {31'd0, Key_Valid}, 32'd1);
            end
        join
        expect_event(1'b0, 1'b0, 8'h1C);
        read_event("ev_1c");
        @(negedge Clk);
        check("1c_drained", {31'd0, Key_Valid}, 32'd0);

        // Prefixes fold into one event.
        send_frame(PS2_EXT, 1'b0);
        send_frame(PS2_REL, 1'b0);
        check("prefix_not_queued", {31'd0, Key_Valid}, 32'd0);
        send_frame(8'h75, 1'b0);
        expect_event(1'b1, 1'b1, 8'h75);
        read_event("ev_e0f075");
        @(negedge Clk);
        check("e0f075_single", {31'd0, Key_Valid}, 32'd0);

        // Overflow: five codes into a 4-deep FIFO.
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b0);
            if (i <= DEPTH) expect_event(1'b0, 1'b0, 8'(i));
        end
        check("overflow_set", {31'd0, Overflow}, 32'd1);
        for (int i = 1; i <= DEPTH; i++) read_event("ev_ovf");
        @(negedge Clk);
        check("ovf_drained", {31'd0, Key_Valid}, 32'd0);
        check("overflow_sticky", {31'd0, Overflow}, 32'd1);

        // Reset clears overflow, then push plus pop on a full FIFO.
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_clears_ovf", {31'd0, Overflow}, 32'd0);
        for (int i = 6; i <= 9; i++) begin
            send_frame(8'(i), 1'b0);
            expect_event(1'b0, 1'b0, 8'(i));
        end
        check("full_no_ovf", {31'd0, Overflow}, 32'd0);
        fork
            send_frame(8'h0A, 1'b0);
            begin
                key_event_t exp;
                wait_byte_done(n);
                check("full_bd_seen", {31'd0, dut.byte_done_q}, 32'd1);
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : 10'h3FF;
                check("full_head", {22'd0, Key_Extended, Key_Release, Key_Code}, {22'd0, exp});
                Rd_En = 1'b1;
                @(negedge Clk);
                Rd_En = 1'b0;
            end
        join
        expect_event(1'b0, 1'b0, 8'h0A);
        check("pushpop_full_no_ovf", {31'd0, Overflow}, 32'd0);
        for (int i = 0; i < DEPTH; i++) read_event("ev_full");
        @(negedge Clk);
        check("full_drained", {31'd0, Key_Valid}, 32'd0);

        // Parity bit flipped.
        fe_before = fe_cnt;
        send_frame(8'h1C, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        check("parity_err_pulse", fe_cnt, fe_before + 1);
        check("parity_no_event", {31'd0, Key_Valid}, 32'd0);
`else
        check("parity_ignored_fe", fe_cnt, fe_before);
        expect_event(1'b0, 1'b0, 8'h1C);
        read_event("ev_parity_ignored");
`endif

        // Timeout after 4 data bits; a pending E0 flag must be cleared by it.
        send_frame(PS2_EXT, 1'b0);
        fe_before = fe_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        n = 0;
        while (fe_cnt == fe_before && n < TO + 50) begin
            @(negedge Clk);
            n++;
        end
        check("timeout_frame_err", fe_cnt, fe_before + 1);
        check("timeout_state_idle", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
        check("timeout_no_event", {31'd0, Key_Valid}, 32'd0);
        send_frame(8'h2A, 1'b0);
        expect_event(1'b0, 1'b0, 8'h2A);
        read_event("ev_after_timeout");

        // Reset mid-frame with two events queued.
        send_frame(8'h11, 1'b0);
        send_frame(8'h12, 1'b0);
        check("two_queued_valid", {31'd0, Key_Valid}, 32'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        fe_before = fe_cnt;
        Reset   = 1'b1;
        KB_Data = 1'b1;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (20) @(negedge Clk);
        sb_q.delete();
        check("midrst_valid", {31'd0, Key_Valid}, 32'd0);
        check("midrst_overflow", {31'd0, Overflow}, 32'd0);
        check("midrst_no_fe", fe_cnt, fe_before);
        send_frame(8'h33, 1'b0);
        expect_event(1'b0, 1'b0, 8'h33);
        read_event("ev_after_reset");
        @(negedge Clk);
        check("final_empty", {31'd0, Key_Valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
